level_tile_arbiter: RTL and testbench

LEVEL_TILE_ARBITER -- requirements
Module: level_tile_arbiter

---
 rtl/level_tile_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_level_tile_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/level_tile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : level_tile_arbiter
//  Description : Sole master of the single-port level memory. It shares the
//                memory between a display prefetcher (which keeps the tile
//                under the raster, plus the next one, ready for the pixel
//                pipeline) and a physics query port (which asks for the
//                type of an arbitrary tile).
//
//  Ports
//    clk         in   1   system clock
//    reset       in   1   synchronous, active-high reset
//    frameStart  in   1   one-cycle pulse at the start of each frame
//    levelSel    in   2   level number, sampled on frameStart
//    hCount      in  10   raster column counter
//    vCount      in  10   raster line counter
//    blockType   out  3   registered tile type for the current pixel
//    memAddr     out 11   level memory address (0 when not reading)
//    memRd       out  1   level memory read strobe
//    memData     in   3   level memory data, valid the cycle after memRd
//    qReq        in   1   physics query request, level-held
//    qRow        in   4   queried tile row
//    qCol        in   5   queried tile column
//    qAck        out  1   query accepted (qRow/qCol sampled this cycle)
//    qValid      out  1   qType valid this cycle
//    qType       out  3   tile type returned for the query
//
//  Revision    : 1.0  initial release
// ============================================================================
module level_tile_arbiter #(
  parameter int H_OFF = 144,
  parameter int V_OFF = 35,
  parameter int COLS  = 20,
  parameter int ROWS  = 15,
  parameter int TILE  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frameStart,
  input  logic [1:0]  levelSel,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [2:0]  blockType,
  output logic [10:0] memAddr,
  output logic        memRd,
  input  logic [2:0]  memData,
  input  logic        qReq,
  input  logic [3:0]  qRow,
  input  logic [4:0]  qCol,
  output logic        qAck,
  output logic        qValid,
  output logic [2:0]  qType
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         c_TSH      = $clog2(TILE);
  localparam logic [9:0] c_H_OFF    = 10'(H_OFF);
  localparam logic [9:0] c_V_OFF    = 10'(V_OFF);
  localparam logic [9:0] c_H_END    = 10'(H_OFF + COLS * TILE);
  localparam logic [9:0] c_V_END    = 10'(V_OFF + ROWS * TILE);
  localparam logic [8:0] c_COLS9    = 9'(COLS);
  localparam logic [4:0] c_COL_LAST = 5'(COLS - 1);
  localparam logic [4:0] c_ROWS5    = 5'(ROWS);
  localparam logic [5:0] c_COLS6    = 6'(COLS);
  // One level occupies ROWS*COLS consecutive words (300 at the defaults).
  localparam logic [10:0] c_LVL_SIZE = 11'(ROWS * COLS);

  // Tags are {valid, tile index}; an all-zero tag is "no tile".
  localparam logic [9:0] c_TAG_NONE = 10'd0;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_DISP_RD = 2'd1;
  localparam logic [1:0] c_PHYS_RD = 2'd2;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] r_level;
  logic [9:0] r_nextTag;
  logic [2:0] r_nextType;
  logic [9:0] r_fetchTag;   // tile being read by the current DISP_RD
  logic [9:0] r_curTag;
  logic [2:0] r_blockType;
  logic       r_qValid;
  logic       r_qFromMem;   // the pending qValid carries memory data
  logic [2:0] r_qType;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [9:0]  w_hx;
  logic [9:0]  w_vy;
  logic [4:0]  w_col;
  logic [3:0]  w_row;
  logic        w_hVis;
  logic        w_vVis;
  logic        w_vis;
  logic [8:0]  w_rowBase;
  logic [8:0]  w_pixIdx;
  logic [9:0]  w_pixTag;
  logic [9:0]  w_dispTgt;
  logic        w_dispNeed;
  logic [8:0]  w_physIdx;
  logic        w_qOob;
  logic        w_qEligible;
  logic [1:0]  w_lvl;
  logic [10:0] w_lvlBase;
  logic [1:0]  w_stateNext;
  logic        w_memRd;
  logic [8:0]  w_rdIdx;
  logic        w_qAck;
  logic [10:0] w_memAddr;

  // --------------------------------------------------------------------------
  // Raster to tile coordinates
  // --------------------------------------------------------------------------
  assign w_hx   = hCount - c_H_OFF;
  assign w_vy   = vCount - c_V_OFF;
  assign w_col  = 5'(w_hx >> c_TSH);
  assign w_row  = 4'(w_vy >> c_TSH);
  assign w_hVis = (hCount >= c_H_OFF) && (hCount < c_H_END);
  assign w_vVis = (vCount >= c_V_OFF) && (vCount < c_V_END);
  assign w_vis  = w_hVis && w_vVis;

  assign w_rowBase = {5'd0, w_row} * c_COLS9;
  assign w_pixIdx  = w_rowBase + {4'd0, w_col};
  assign w_pixTag  = {1'b1, w_pixIdx};

  // Prefetch target: the tile to the right of the current one while drawing,
  // or column 0 of the line during the left blanking interval.
  always_comb begin
    w_dispTgt = c_TAG_NONE;
    if (w_vis) begin
      if (w_col < c_COL_LAST) begin
        w_dispTgt = {1'b1, w_pixIdx + 9'd1};
      end
    end else if (w_vVis && (hCount < c_H_OFF)) begin
      w_dispTgt = {1'b1, w_rowBase};
    end
  end

  assign w_dispNeed = w_dispTgt[9] && (w_dispTgt != r_nextTag);

  // --------------------------------------------------------------------------
  // Physics query decode
  // --------------------------------------------------------------------------
  assign w_physIdx   = ({5'd0, qRow} * c_COLS9) + {4'd0, qCol};
  assign w_qOob      = ({1'b0, qRow} >= c_ROWS5) || ({1'b0, qCol} >= c_COLS6);
  // While qValid is shown the previous query is still completing; a held
  // qReq only counts as a new request after that cycle.
  assign w_qEligible = qReq && !r_qValid;

  // A fetch issued in the frameStart cycle already belongs to the new level.
  assign w_lvl     = frameStart ? levelSel : r_level;
  assign w_lvlBase = {9'd0, w_lvl} * c_LVL_SIZE;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Read states last one cycle (the data-return cycle).
  // --------------------------------------------------------------------------
  always_comb begin
    w_stateNext = c_IDLE;
    case (r_state)
      c_IDLE: begin
        if (w_dispNeed) begin
          w_stateNext = c_DISP_RD;
        end else if (w_qEligible && !w_qOob) begin
          w_stateNext = c_PHYS_RD;
        end
      end
      default: w_stateNext = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. The read strobe is issued from IDLE so that the data is
  // present during the following read state. Out-of-range queries never
  // touch memory, so they are acknowledged even while display fetches.
  // --------------------------------------------------------------------------
  always_comb begin
    w_memRd = 1'b0;
    w_rdIdx = 9'd0;
    w_qAck  = 1'b0;
    if (!reset && (r_state == c_IDLE)) begin
      if (w_dispNeed) begin
        w_memRd = 1'b1;
        w_rdIdx = w_dispTgt[8:0];
        if (w_qEligible && w_qOob) begin
          w_qAck = 1'b1;
        end
      end else if (w_qEligible) begin
        w_qAck = 1'b1;
        if (!w_qOob) begin
          w_memRd = 1'b1;
          w_rdIdx = w_physIdx;
        end
      end
    end
  end

  assign w_memAddr = w_memRd ? (w_lvlBase + {2'b00, w_rdIdx}) : 11'd0;

  // --------------------------------------------------------------------------
  // Level register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= 2'd0;
    end else if (frameStart) begin
      r_level <= levelSel;
    end
  end

  // --------------------------------------------------------------------------
  // Prefetch buffer. frameStart is applied last so it wins over a capture
  // that may still hold data from the previous level.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nextTag  <= c_TAG_NONE;
      r_nextType <= 3'd0;
      r_fetchTag <= c_TAG_NONE;
    end else begin
      if ((r_state == c_IDLE) && (w_stateNext == c_DISP_RD)) begin
        r_fetchTag <= w_dispTgt;
      end
      if (r_state == c_DISP_RD) begin
        r_nextType <= memData;
        r_nextTag  <= r_fetchTag;
      end
      if (frameStart) begin
        r_nextTag <= c_TAG_NONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel pipeline: one register stage behind the raster.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blockType <= 3'd0;
      r_curTag    <= c_TAG_NONE;
    end else begin
      if (!w_vis) begin
        r_blockType <= 3'd0;
        r_curTag    <= c_TAG_NONE;
      end else if ((w_pixTag == r_nextTag) && (w_pixTag != r_curTag)) begin
        r_blockType <= r_nextType;
        r_curTag    <= r_nextTag;
      end
      if (frameStart) begin
        r_curTag <= c_TAG_NONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Physics response. In-range queries forward memData during the qValid
  // cycle and latch it for the hold period; out-of-range queries answer 1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_qValid   <= 1'b0;
      r_qFromMem <= 1'b0;
      r_qType    <= 3'd0;
    end else begin
      r_qValid <= w_qAck;
      if (w_qAck) begin
        r_qFromMem <= !w_qOob;
        if (w_qOob) begin
          r_qType <= 3'd1;
        end
      end
      if (r_qValid && r_qFromMem) begin
        r_qType <= memData;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Reset also masks the data-return cycle so an interrupted access
  // never produces a response.
  // --------------------------------------------------------------------------
  assign blockType = r_blockType;
  assign memRd     = w_memRd;
  assign memAddr   = w_memAddr;
  assign qAck      = w_qAck;
  assign qValid    = r_qValid && !reset;
  assign qType     = reset ? 3'd0 :
                     ((r_qValid && r_qFromMem) ? memData : r_qType);

endmodule
`default_nettype wire

// File: tb/tb_level_tile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_level_tile_arbiter
//  Description : Directed self-checking bench for level_tile_arbiter with a
//                synchronous-read level memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_level_tile_arbiter;

  logic        clk;
  logic        reset;
  logic        frameStart;
  logic [1:0]  levelSel;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [2:0]  blockType;
  logic [10:0] memAddr;
  logic        memRd;
  logic [2:0]  memData;
  logic        qReq;
  logic [3:0]  qRow;
  logic [4:0]  qCol;
  logic        qAck;
  logic        qValid;
  logic [2:0]  qType;

  int errors = 0;
  int checks = 0;
  int rdCount = 0;
  int rd0;
  int prevH;

  logic [2:0] mem [0:1199];

  level_tile_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .frameStart (frameStart),
    .levelSel   (levelSel),
    .hCount     (hCount),
    .vCount     (vCount),
    .blockType  (blockType),
    .memAddr    (memAddr),
    .memRd      (memRd),
    .memData    (memData),
    .qReq       (qReq),
    .qRow       (qRow),
    .qCol       (qCol),
    .qAck       (qAck),
    .qValid     (qValid),
    .qType      (qType)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (memRd === 1'b1) begin
      memData <= mem[memAddr];
      rdCount <= rdCount + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (qAck !== 1'b1 && n < 4) begin
      adv();
      mid();
      n++;
    end
    chk(tag, 16'(qAck), 16'd1);
  endtask

  function automatic logic [15:0] sweep_exp(input int h);
    if (h >= 208 && h <= 239) return 16'd3;
    if (h >= 240 && h <= 271) return 16'd2;
    return 16'd0;
  endfunction

  initial begin
    for (int i = 0; i < 1200; i++) mem[i] = 3'd0;
    mem[24]  = 3'd5;   // level 0, row 1, col 4
    mem[42]  = 3'd3;   // level 0, row 2, col 2
    mem[43]  = 3'd2;   // level 0, row 2, col 3
    mem[640] = 3'd6;   // level 2, row 2, col 0
    memData    = 3'd0;
    reset      = 1'b1;
    frameStart = 1'b0;
    levelSel   = 2'd0;
    hCount     = 10'd0;
    vCount     = 10'd0;
    qReq       = 1'b1;
    qRow       = 4'd1;
    qCol       = 5'd4;

    // Reset with a request held
    adv(); mid();
    chk("rst_blockType", 16'(blockType), 16'd0);
    chk("rst_qAck",      16'(qAck),      16'd0);
    chk("rst_qValid",    16'(qValid),    16'd0);
    chk("rst_qType",     16'(qType),     16'd0);
    chk("rst_memRd",     16'(memRd),     16'd0);
    chk("rst_memAddr",   16'(memAddr),   16'd0);
    adv(); mid();
    chk("rst2_qAck",     16'(qAck),      16'd0);

    // First query after reset: row 1, col 4
    adv(); reset = 1'b0; mid();
    wait_ack("post_rst_ack");
    chk("post_rst_memRd",   16'(memRd),   16'd1);
    chk("post_rst_memAddr", 16'(memAddr), 16'd24);
    adv(); qReq = 1'b0; mid();
    chk("q1_qValid", 16'(qValid), 16'd1);
    chk("q1_qType",  16'(qType),  16'd5);
    chk("q1_qAck",   16'(qAck),   16'd0);
    adv(); mid();
    chk("q1_qValid_end", 16'(qValid), 16'd0);
    chk("q1_qType_hold", 16'(qType),  16'd5);

    // Out-of-range query held high: immediate answer, re-request after qValid
    adv(); qReq = 1'b1; qRow = 4'd15; qCol = 5'd0; rd0 = rdCount; mid();
    chk("oob_ack",   16'(qAck),  16'd1);
    chk("oob_memRd", 16'(memRd), 16'd0);
    adv(); mid();
    chk("oob_qValid",  16'(qValid), 16'd1);
    chk("oob_qType",   16'(qType),  16'd1);
    chk("oob_noreack", 16'(qAck),   16'd0);
    adv(); mid();
    chk("oob_reack", 16'(qAck), 16'd1);
    adv(); qReq = 1'b0; mid();
    chk("oob_qValid2", 16'(qValid), 16'd1);
    adv(); mid();
    chk("oob_no_mem_reads", 16'(rdCount - rd0), 16'd0);

    // Line sweep over row 2 of level 0
    rd0 = rdCount;
    prevH = 0;
    for (int h = 100; h <= 799; h++) begin
      adv(); vCount = 10'd99; hCount = 10'(h); mid();
      chk("sweep_blockType", 16'(blockType), sweep_exp(prevH));
      prevH = h;
    end
    adv(); mid();
    chk("sweep_reads_per_line", 16'(rdCount - rd0), 16'd20);

    // Query arriving together with a due display fetch
    adv(); hCount = 10'd100; qReq = 1'b1; qRow = 4'd1; qCol = 5'd4; mid();
    chk("arb_disp_memRd",   16'(memRd),   16'd1);
    chk("arb_disp_memAddr", 16'(memAddr), 16'd40);
    chk("arb_disp_noack",   16'(qAck),    16'd0);
    adv(); mid();
    chk("arb_disprd_noack", 16'(qAck),  16'd0);
    chk("arb_disprd_memRd", 16'(memRd), 16'd0);
    adv(); mid();
    chk("arb_qAck",    16'(qAck),    16'd1);
    chk("arb_memAddr", 16'(memAddr), 16'd24);
    adv(); qReq = 1'b0; mid();
    chk("arb_qValid", 16'(qValid), 16'd1);
    chk("arb_qType",  16'(qType),  16'd5);

    // Level select without frameStart has no effect
    adv(); hCount = 10'd0; vCount = 10'd0; levelSel = 2'd2; qReq = 1'b1; mid();
    wait_ack("lvl_nofs_ack");
    chk("lvl_nofs_memAddr", 16'(memAddr), 16'd24);
    adv(); qReq = 1'b0; mid();
    adv(); frameStart = 1'b1; mid();
    adv(); frameStart = 1'b0; vCount = 10'd99; hCount = 10'd100; mid();
    chk("lvl_fs_memRd",   16'(memRd),   16'd1);
    chk("lvl_fs_memAddr", 16'(memAddr), 16'd640);
    adv(); mid();
    adv(); mid();
    adv(); hCount = 10'd144; mid();
    adv(); hCount = 10'd145; mid();
    chk("lvl_fs_blockType", 16'(blockType), 16'd6);

    // Leaving the visible area
    adv(); hCount = 10'd800; mid();
    chk("hidden_lag", 16'(blockType), 16'd6);
    adv(); mid();
    chk("hidden_blockType", 16'(blockType), 16'd0);

    // Reset during a physics read abandons the response
    adv(); qReq = 1'b1; qRow = 4'd1; qCol = 5'd4; mid();
    wait_ack("rstmid_ack");
    chk("rstmid_memAddr", 16'(memAddr), 16'd624);
    adv(); reset = 1'b1; qReq = 1'b0; mid();
    chk("rstmid_qValid", 16'(qValid), 16'd0);
    adv(); reset = 1'b0; mid();
    chk("rstmid_qValid_after", 16'(qValid), 16'd0);
    chk("rstmid_qType",        16'(qType),  16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
